// File: rtl/rst_sync_seq.sv
// rst_sync_seq: synchronises the asynchronous active-low RST into CLK,
// stretches reset for MIN_ASSERT cycles, then releases NUM_CH reset channels
// one at a time (bit 0 first) spaced by GAP_CYCLES. Once every channel is out of
// reset, software can re-enter reset through a 4-phase REQ/ACK handshake.
module rst_sync_seq #(
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 4,
    parameter int MIN_ASSERT = 16,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST_REQ,
    output logic              SW_RST_ACK,
    output logic [NUM_CH-1:0] RST_OUT,
    output logic              RST_DONE
);

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_STRETCH = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_SWRST   = 3'd4;

    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  rst_n_s;
    logic                  rst_n_rise;
    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CH-1:0]     rst_out_q, rst_out_d;
    logic [NUM_CH-1:0]     rst_out_next;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;

    assign rst_n_s = sync_q[NUM_STAGES-1];

    // Next-state logic: sync chain shift, release sequencing and SW handshake
    always_comb begin
        sync_d       = {sync_q[NUM_STAGES-2:0], 1'b1};
        // HOLD exits on the very edge that sets the last sync stage, so E0 is
        // the edge on which rst_n_s rises rather than one cycle later.
        rst_n_rise   = sync_d[NUM_STAGES-1] & ~rst_n_s;
        // The released mask is a thermometer code: each release shifts in
        // one more 1 from bit 0, which doubles as the channel index.
        rst_out_next = (rst_out_q << 1) | NUM_CH'(1);

        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        ack_d     = ack_q;

        case (state_q)
            S_HOLD: begin
                if (rst_n_rise) begin
                    state_d = S_STRETCH;
                    cnt_d   = STRETCH_LOAD;
                end
            end
            S_STRETCH, S_RELEASE: begin
                if (cnt_q == '0) begin
                    rst_out_d = rst_out_next;
                    if (&rst_out_next) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (SW_RST_REQ) begin
                    state_d   = S_SWRST;
                    rst_out_d = '0;
                    done_d    = 1'b0;
                    ack_d     = 1'b1;
                end
            end
            S_SWRST: begin
                if (!SW_RST_REQ) begin
                    state_d = S_STRETCH;
                    ack_d   = 1'b0;
                    cnt_d   = STRETCH_LOAD;
                end
            end
            default: begin
                state_d   = S_HOLD;
                rst_out_d = '0;
                done_d    = 1'b0;
                ack_d     = 1'b0;
            end
        endcase
    end

    // State registers; RST low clears everything with no clock required
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q    <= '0;
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            rst_out_q <= '0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
        end
    end

    assign RST_OUT    = rst_out_q;
    assign RST_DONE   = done_q;
    assign SW_RST_ACK = ack_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// tb_rst_sync_seq: checks reset synchronisation, ordered channel release,
// asynchronous reset assertion, the software reset handshake and a
// single-channel configuration.
module tb_rst_sync_seq;

    typedef struct {
        int         off;
        logic [3:0] out;
        logic       done;
        logic       ack;
    } row_t;

    typedef struct {
        int unsigned at;
        bit          which;
        logic [3:0]  out;
        logic        done;
        logic        ack;
        string       name;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ;
    logic       ACK;
    logic [3:0] OUT;
    logic       DONE;

    logic       RST5;
    logic       REQ5;
    logic       ACK5;
    logic [0:0] OUT5;
    logic       DONE5;

    always #5 CLK = ~CLK;

    rst_sync_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (REQ),
        .SW_RST_ACK (ACK),
        .RST_OUT    (OUT),
        .RST_DONE   (DONE)
    );

    rst_sync_seq #(
        .NUM_STAGES (3),
        .NUM_CH     (1),
        .MIN_ASSERT (1),
        .GAP_CYCLES (1)
    ) dut5 (
        .CLK        (CLK),
        .RST        (RST5),
        .SW_RST_REQ (REQ5),
        .SW_RST_ACK (ACK5),
        .RST_OUT    (OUT5),
        .RST_DONE   (DONE5)
    );

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    row_t tbl[10];

    // Scoreboard: compare every expectation due on this cycle
    always @(negedge CLK) begin
        exp_t       e;
        logic [5:0] act;
        logic [5:0] req;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.at < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not reached (now %0d)", e.name, e.at, cyc);
            end else begin
                act = e.which ? {3'b000, OUT5, DONE5, ACK5} : {OUT, DONE, ACK};
                req = {e.out, e.done, e.ack};
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL %s: {RST_OUT,DONE,ACK} got %b required %b", e.name, act, req);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [5:0] act, input logic [5:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: {RST_OUT,DONE,ACK} got %b required %b", name, act, req);
        end
    endtask

    task automatic push(input int unsigned at, input bit which, input logic [3:0] out,
                        input logic done, input logic ack, input string name);
        exp_t e;
        e.at = at; e.which = which; e.out = out; e.done = done; e.ack = ack; e.name = name;
        sb.push_back(e);
    endtask

    // Queue the release-sequence checkpoints relative to E0
    task automatic push_seq(input int unsigned e0, input int maxoff, input bit pre, input string tag);
        if (pre) push(e0 - 1, 1'b0, 4'b0000, 1'b0, 1'b0, $sformatf("%s_e0-1", tag));
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].off <= maxoff)
                push(e0 + int'(tbl[i].off), 1'b0, tbl[i].out, tbl[i].done, tbl[i].ack,
                     $sformatf("%s_e0+%0d", tag, tbl[i].off));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) step();
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (sb.size() > 0 && i < 300) begin
            @(negedge CLK);
            #1;
            i++;
        end
        n_vec++;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain_%s: %0d checks pending, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned e0;
        int unsigned c;
        int unsigned t;

        tbl[0] = '{0,  4'b0000, 1'b0, 1'b0};
        tbl[1] = '{15, 4'b0000, 1'b0, 1'b0};
        tbl[2] = '{16, 4'b0001, 1'b0, 1'b0};
        tbl[3] = '{23, 4'b0001, 1'b0, 1'b0};
        tbl[4] = '{24, 4'b0011, 1'b0, 1'b0};
        tbl[5] = '{31, 4'b0011, 1'b0, 1'b0};
        tbl[6] = '{32, 4'b0111, 1'b0, 1'b0};
        tbl[7] = '{39, 4'b0111, 1'b0, 1'b0};
        tbl[8] = '{40, 4'b1111, 1'b1, 1'b0};
        tbl[9] = '{41, 4'b1111, 1'b1, 1'b0};

        RST  = 1'b0;
        REQ  = 1'b0;
        RST5 = 1'b0;
        REQ5 = 1'b0;
        #1;
        check_now("reset_state", {OUT, DONE, ACK}, 6'b0);
        check_now("reset_state_ch1", {3'b000, OUT5, DONE5, ACK5}, 6'b0);

        // Test 1: power-on release
        repeat (5) step();
        RST  = 1'b1;
        base = cyc;
        push_seq(base + 2, 41, 1'b1, "t1");
        drain("t1");

        // Test 2: asynchronous assertion mid-sequence, then a full repeat
        RST = 1'b0;
        step();
        step();
        RST  = 1'b1;
        base = cyc;
        e0   = base + 2;
        push_seq(e0, 23, 1'b1, "t2a");
        wait_until(e0 + 24);
        check_now("t2_before_drop", {OUT, DONE, ACK}, {4'b0011, 1'b0, 1'b0});
        RST = 1'b0;
        #1;
        check_now("t2_async_drop", {OUT, DONE, ACK}, 6'b0);
        repeat (3) step();
        check_now("t2_held_low", {OUT, DONE, ACK}, 6'b0);
        RST  = 1'b1;
        base = cyc;
        push_seq(base + 2, 41, 1'b1, "t2b");
        drain("t2");

        // Tests 3 and 4: SW request for 10 cycles, then a request raised mid-release
        step();
        c   = cyc;
        REQ = 1'b1;
        push(c,      1'b0, 4'b1111, 1'b1, 1'b0, "t3_run");
        push(c + 1,  1'b0, 4'b0000, 1'b0, 1'b1, "t3_swrst_entry");
        push(c + 5,  1'b0, 4'b0000, 1'b0, 1'b1, "t3_swrst_hold5");
        push(c + 10, 1'b0, 4'b0000, 1'b0, 1'b1, "t3_swrst_hold10");
        e0 = c + 11;
        push_seq(e0, 40, 1'b0, "t3");
        push(e0 + 41, 1'b0, 4'b0000, 1'b0, 1'b1, "t4_swrst_entry");
        push(e0 + 45, 1'b0, 4'b0000, 1'b0, 1'b1, "t4_swrst_hold");
        wait_until(c + 10);
        REQ = 1'b0;
        wait_until(e0 + 20);
        REQ = 1'b1;
        wait_until(e0 + 45);
        REQ = 1'b0;
        push_seq(e0 + 46, 41, 1'b0, "t4_rerelease");
        drain("t34");

        // Test 6: half-period glitch on RST while running
        step();
        t = cyc;
        check_now("t6_before_glitch", {OUT, DONE, ACK}, {4'b1111, 1'b1, 1'b0});
        RST = 1'b0;
        #1;
        check_now("t6_glitch_drop", {OUT, DONE, ACK}, 6'b0);
        #4;
        RST = 1'b1;
        push_seq(t + 2, 41, 1'b1, "t6");
        drain("t6");

        // Test 5: three-stage sync, single channel, minimum timings
        step();
        t    = cyc;
        RST5 = 1'b1;
        push(t + 2, 1'b1, 4'b0000, 1'b0, 1'b0, "t5_edge2");
        push(t + 3, 1'b1, 4'b0000, 1'b0, 1'b0, "t5_edge3_e0");
        push(t + 4, 1'b1, 4'b0001, 1'b1, 1'b0, "t5_edge4_release");
        push(t + 6, 1'b1, 4'b0001, 1'b1, 1'b0, "t5_run_hold");
        drain("t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
